// File: rtl/accumulate_bias.sv
// Per-lane saturating accumulator: sums DEPTH product vectors onto a bias.
// Ports: clock/reset, bias_load/bias_in, clear, prod_valid/product_in -> pixel_out/pixel_valid/sat_flag/busy.
module accumulate_bias #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bias_load,
  input  logic [32*SIZE-1:0]  bias_in,
  input  logic                clear,
  input  logic                prod_valid,
  input  logic [16*SIZE-1:0]  product_in,
  output logic [32*SIZE-1:0]  pixel_out,
  output logic                pixel_valid,
  output logic [SIZE-1:0]     sat_flag,
  output logic                busy
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic [CW-1:0]          cnt;
  logic [SIZE-1:0][31:0]  acc;
  logic [SIZE-1:0][31:0]  bias;
  logic [SIZE-1:0][31:0]  sum;
  logic [SIZE-1:0]        s;
  logic [SIZE-1:0]        clamp;
  logic [SIZE-1:0]        s_next;
  logic                   first;
  logic                   last;

  assign first = (cnt == '0);
  assign last  = (cnt == LAST);
  assign busy  = (cnt != '0);

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [31:0] base;
    logic [32:0] wide;
    // A window opens from the registered bias; later terms build on acc.
    assign base = first ? bias[i] : acc[i];
    assign wide = {base[31], base}
                + {{17{product_in[16*i+15]}}, product_in[16*i +: 16]};
    // Carry into the guard bit disagreeing with bit 31 means overflow;
    // the guard bit then gives the true sign.
    assign clamp[i] = wide[32] ^ wide[31];
    assign sum[i]   = clamp[i] ? (wide[32] ? SMIN : SMAX)
                               : wide[31:0];
  end

  // Sticky flags restart with each window's first term.
  assign s_next = (first ? '0 : s) | clamp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      acc         <= '0;
      s           <= '0;
      bias        <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      sat_flag    <= '0;
    end else begin
      pixel_valid <= 1'b0;
      if (bias_load) bias <= bias_in;
      if (clear) begin
        cnt <= '0;
        s   <= '0;
      end else if (prod_valid) begin
        if (last) begin
          pixel_out   <= sum;
          sat_flag    <= s_next;
          pixel_valid <= 1'b1;
          cnt         <= '0;
          s           <= '0;
        end else begin
          acc <= sum;
          s   <= s_next;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulate_bias.sv
// Bench for accumulate_bias: vector table, DEPTH=1 sequences,
// and random stimulus against an arithmetic reference model.
module tb_accumulate_bias;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        bl;
  logic [63:0] bin;
  logic        clr;
  logic        pv;
  logic [31:0] pin;
  logic [63:0] po3, po1;
  logic        v3, v1, b3, b1;
  logic [1:0]  s3, s1;

  accumulate_bias #(.SIZE(2), .DEPTH(3)) u3 (
    .clock(clk), .reset(rst_n), .bias_load(bl), .bias_in(bin),
    .clear(clr), .prod_valid(pv), .product_in(pin),
    .pixel_out(po3), .pixel_valid(v3), .sat_flag(s3), .busy(b3)
  );

  accumulate_bias #(.SIZE(2), .DEPTH(1)) u1 (
    .clock(clk), .reset(rst_n), .bias_load(bl), .bias_in(bin),
    .clear(clr), .prod_valid(pv), .product_in(pin),
    .pixel_out(po1), .pixel_valid(v1), .sat_flag(s1), .busy(b1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Reference model: index 0 = DEPTH 3 instance, 1 = DEPTH 1 instance.
  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;
  int          dep [2] = '{3, 1};
  longint      mb  [2];
  int          mn  [2];
  longint      macc[2][2];
  bit          ms  [2][2];
  logic [31:0] mpo [2][2];
  bit          msat[2][2];
  bit          mv  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mn[d] = 0;
      mv[d] = 0;
      for (int l = 0; l < 2; l++) begin
        mb[l] = 0; macc[d][l] = 0; ms[d][l] = 0;
        mpo[d][l] = 0; msat[d][l] = 0;
      end
    end
  endtask

  task automatic model_step();
    longint base, v;
    bit c;
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0;
      if (clr) begin
        mn[d] = 0;
        ms[d][0] = 0; ms[d][1] = 0;
      end else if (pv) begin
        for (int l = 0; l < 2; l++) begin
          base = (mn[d] == 0) ? mb[l] : macc[d][l];
          v = base + longint'($signed(pin[16*l +: 16]));
          c = 0;
          if (v > MAXV) begin v = MAXV; c = 1; end
          else if (v < MINV) begin v = MINV; c = 1; end
          if (mn[d] == 0) ms[d][l] = 0;
          ms[d][l] = ms[d][l] | c;
          macc[d][l] = v;
          if (mn[d] == dep[d] - 1) begin
            mpo[d][l]  = v[31:0];
            msat[d][l] = ms[d][l];
          end
        end
        if (mn[d] == dep[d] - 1) begin
          mv[d] = 1;
          mn[d] = 0;
          ms[d][0] = 0; ms[d][1] = 0;
        end else begin
          mn[d]++;
        end
      end
    end
    if (bl) for (int l = 0; l < 2; l++)
      mb[l] = longint'($signed(bin[32*l +: 32]));
  endtask

  task automatic cyc(input logic [31:0] ibl, b0, b1, iclr, ipv, p0, p1);
    bl  = ibl[0];
    bin = {b1, b0};
    clr = iclr[0];
    pv  = ipv[0];
    pin = {p1[15:0], p0[15:0]};
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        bl;
    logic [31:0] b0, b1;
    logic        clr, pv;
    logic [31:0] p0, p1;
    logic        ev;
    logic [31:0] e0, e1;
    logic [1:0]  es;
    logic        eb;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ibl, b0, b1, iclr, ipv,
                              p0, p1, ev, e0, e1, es, eb);
    vec_t t;
    t.bl = ibl[0]; t.b0 = b0; t.b1 = b1; t.clr = iclr[0]; t.pv = ipv[0];
    t.p0 = p0; t.p1 = p1; t.ev = ev[0]; t.e0 = e0; t.e1 = e1;
    t.es = es[1:0]; t.eb = eb[0];
    return t;
  endfunction

  task automatic do_reset();
    #2 rst_n = 1'b0;
    bl = 0; bin = '0; clr = 0; pv = 0; pin = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl[$];
  logic [31:0] h0, h1;
  logic [1:0]  hs;
  logic [31:0] rb0, rb1;
  int          vcnt;

  function automatic logic [31:0] rbias();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'h7FFF_FF00 + $urandom_range(0, 255);
      2: return 32'h8000_0100 - $urandom_range(0, 255);
      default: return $urandom_range(0, 2000) - 1000;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    bl = 0; bin = '0; clr = 0; pv = 0; pin = '0;
    model_reset();
    #1;
    chk("async reset pixel_out", po3, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset pixel_out", po3, 64'h0);
    chk("reset pixel_valid", {63'h0, v3}, 64'h0);
    chk("reset sat_flag", {62'h0, s3}, 64'h0);
    chk("reset busy", {63'h0, b3}, 64'h0);

    // DEPTH=3 vector table
    tbl.push_back(mk(1, 100, -5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 10, -1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 20, -1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 30, -1, 1, 160, -8, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 2, 1, 106, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 100, -5, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 103, -2, 0, 0));
    tbl.push_back(mk(1, 32'h7FFFFF00, 32'h80000100, 0, 0, 0, 0,
                     0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h7FFF, -32768, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, -1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,
                     1, 32'h7FFFFFFE, 32'h80000001, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, -5, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, -5, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, -5, 1, 15, -15, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 0, 0));
    tbl.push_back(mk(1, 7, 7, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 10, 10, 0, 0));

    h0 = '0; h1 = '0; hs = '0;
    foreach (tbl[i]) begin
      cyc({31'h0, tbl[i].bl}, tbl[i].b0, tbl[i].b1, {31'h0, tbl[i].clr},
          {31'h0, tbl[i].pv}, tbl[i].p0, tbl[i].p1);
      if (tbl[i].ev) begin
        h0 = tbl[i].e0; h1 = tbl[i].e1; hs = tbl[i].es;
      end
      chk($sformatf("row%0d valid", i), {63'h0, v3}, {63'h0, tbl[i].ev});
      chk($sformatf("row%0d pixel_out", i), po3, {h1, h0});
      chk($sformatf("row%0d sat_flag", i), {62'h0, s3}, {62'h0, hs});
      chk($sformatf("row%0d busy", i), {63'h0, b3}, {63'h0, tbl[i].eb});
    end

    // DEPTH=1: bias-load collision, streaming, async reset mid-cycle
    do_reset();
    cyc(1, 7, 7, 0, 1, 1, 1);
    chk("d1 collision valid", {63'h0, v1}, 64'h1);
    chk("d1 collision old bias", po1, {32'd1, 32'd1});
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("d1 new bias", po1, {32'd8, 32'd8});
    vcnt = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 1, k + 1, -(k + 1));
      if (v1) vcnt++;
      chk($sformatf("d1 stream%0d", k), po1,
          {32'(7 - (k + 1)), 32'(7 + k + 1)});
    end
    chk("d1 stream valid count", 64'(vcnt), 64'd5);
    chk("d1 sat clear", {62'h0, s1}, 64'h0);
    #3 rst_n = 1'b0;
    #1;
    chk("midcycle reset po1", po1, 64'h0);
    chk("midcycle reset v1", {63'h0, v1}, 64'h0);
    chk("midcycle reset po3", po3, 64'h0);
    chk("midcycle reset busy3", {63'h0, b3}, 64'h0);
    do_reset();

    // Random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      rb0 = rbias();
      rb1 = rbias();
      cyc(($urandom_range(0, 15) == 0) ? 1 : 0, rb0, rb1,
          ($urandom_range(0, 19) == 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          ($urandom_range(0, 1) == 1) ? $urandom
                                      : $urandom_range(0, 64) - 32,
          $urandom);
      chk("rnd v3", {63'h0, v3}, {63'h0, mv[0]});
      chk("rnd po3", po3, {mpo[0][1], mpo[0][0]});
      chk("rnd s3", {62'h0, s3}, {62'h0, msat[0][1], msat[0][0]});
      chk("rnd b3", {63'h0, b3}, {63'h0, (mn[0] != 0)});
      chk("rnd v1", {63'h0, v1}, {63'h0, mv[1]});
      chk("rnd po1", po1, {mpo[1][1], mpo[1][0]});
      chk("rnd s1", {62'h0, s1}, {62'h0, msat[1][1], msat[1][0]});
      chk("rnd b1", {63'h0, b1}, 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
